// File: rtl/alu_div.sv
// rtl/alu_div.sv - sequential binary32 divider: 25-step restoring mantissa division,
// denormals flushed to zero, quotient truncated, special cases on the esp bus.
module alu_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] Resultado,
  output logic [1:0]  esp,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLASSIFY = 3'd1;
  localparam logic [2:0] S_DIVIDE   = 3'd2;
  localparam logic [2:0] S_NORM     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [1:0] ESP_NORMAL = 2'b00;
  localparam logic [1:0] ESP_NAN    = 2'b01;
  localparam logic [1:0] ESP_DIVZ   = 2'b10;
  localparam logic [1:0] ESP_INF    = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [2:0]  state;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [25:0] rem;
  logic [24:0] quo;
  logic [4:0]  cnt;

  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic        a_zero, a_inf, a_nan;
  logic        b_zero, b_inf, b_nan;
  logic        sign;

  assign exp_a  = op_a[30:23];
  assign exp_b  = op_b[30:23];
  assign a_zero = (exp_a == 8'h00);
  assign b_zero = (exp_b == 8'h00);
  assign a_inf  = (exp_a == 8'hFF) && (op_a[22:0] == 23'h0);
  assign b_inf  = (exp_b == 8'hFF) && (op_b[22:0] == 23'h0);
  assign a_nan  = (exp_a == 8'hFF) && (op_a[22:0] != 23'h0);
  assign b_nan  = (exp_b == 8'hFF) && (op_b[22:0] != 23'h0);
  assign sign   = op_a[31] ^ op_b[31];

  // Special-case resolution in priority order; is_special low selects the divide path.
  logic        is_special;
  logic [31:0] spec_res;
  logic [1:0]  spec_esp;

  always_comb begin
    is_special = 1'b1;
    spec_res   = QNAN;
    spec_esp   = ESP_NAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = QNAN;
      spec_esp = ESP_NAN;
    end else if (b_zero) begin
      spec_res = {sign, 8'hFF, 23'h0};
      spec_esp = a_inf ? ESP_INF : ESP_DIVZ;
    end else if (a_inf) begin
      spec_res = {sign, 8'hFF, 23'h0};
      spec_esp = ESP_INF;
    end else if (a_zero || b_inf) begin
      spec_res = {sign, 31'h0};
      spec_esp = ESP_NORMAL;
    end else begin
      is_special = 1'b0;
    end
  end

  // One restoring step: trial subtract of the divisor, keep it only if non-negative.
  logic [25:0] divisor;
  logic [25:0] rem_sub;
  logic        rem_ge;

  assign divisor = {3'b001, op_b[22:0]};
  assign rem_ge  = (rem >= divisor);
  assign rem_sub = rem_ge ? (rem - divisor) : rem;

  // Exponent is kept signed and wide so underflow and overflow are both visible.
  logic signed [9:0] exp_q;
  logic [22:0]       mant_q;

  assign exp_q  = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b})
                + (quo[24] ? 10'sd127 : 10'sd126);
  assign mant_q = quo[24] ? quo[23:1] : quo[22:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_a      <= 32'h0;
      op_b      <= 32'h0;
      rem       <= 26'h0;
      quo       <= 25'h0;
      cnt       <= 5'h0;
      Resultado <= 32'h0;
      esp       <= ESP_NORMAL;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a  <= dataA;
            op_b  <= dataB;
            state <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          if (is_special) begin
            Resultado <= spec_res;
            esp       <= spec_esp;
            state     <= S_DONE;
          end else begin
            rem   <= {3'b001, op_a[22:0]};
            quo   <= 25'h0;
            cnt   <= 5'h0;
            state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          quo <= {quo[23:0], rem_ge};
          rem <= rem_sub << 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24) begin
            state <= S_NORM;
          end
        end
        S_NORM: begin
          if (exp_q >= 10'sd255) begin
            Resultado <= {sign, 8'hFF, 23'h0};
            esp       <= ESP_INF;
          end else if (exp_q <= 10'sd0) begin
            Resultado <= {sign, 31'h0};
            esp       <= ESP_NORMAL;
          end else begin
            Resultado <= {sign, exp_q[7:0], mant_q};
            esp       <= ESP_NORMAL;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_alu_div.sv
// tb/tb_alu_div.sv - directed and randomized checks of alu_div against an arithmetic
// reference model of binary32 division with flush-to-zero and truncation.
module tb_alu_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataA = 32'h0;
  logic [31:0] dataB = 32'h0;
  logic [31:0] Resultado;
  logic [1:0]  esp;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  alu_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dataA     (dataA),
    .dataB     (dataB),
    .Resultado (Resultado),
    .esp       (esp),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: {special, esp, result} from the classification rules and integer division.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, e;
    bit     az, ai, an, bz, bi, bn, s;
    longint ma, mb, q, mant;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    s  = a[31] ^ b[31];
    if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 2'b01, 32'h7FC0_0000};
    if (bz && !ai) return {1'b1, 2'b10, s, 31'h7F80_0000};
    if (ai) return {1'b1, 2'b11, s, 31'h7F80_0000};
    if (az || bi) return {1'b1, 2'b00, s, 31'h0};
    ma = 64'h80_0000 + longint'(a[22:0]);
    mb = 64'h80_0000 + longint'(b[22:0]);
    q  = (ma * 64'h100_0000) / mb;
    if (q >= 64'h100_0000) begin
      mant = (q / 2) % 64'h80_0000;
      e    = ea - eb + 127;
    end else begin
      mant = q % 64'h80_0000;
      e    = ea - eb + 126;
    end
    if (e >= 255) return {1'b0, 2'b11, s, 31'h7F80_0000};
    if (e <= 0) return {1'b0, 2'b00, s, 31'h0};
    return {1'b0, 2'b00, s, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0: x[30:23] = 8'h00;
      1: x[30:23] = 8'hFF;
      2: begin x[30:23] = 8'hFF; x[22:0] = 23'h0; end
      3: x[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFE : 8'h01;
      default: ;
    endcase
    return x;
  endfunction

  // Issue one operation; poke>0 drives a competing start on that busy cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int poke,
                       output logic [31:0] r, output logic [1:0] e,
                       output int busy_cyc, output int done_cyc);
    @(negedge clk);
    dataA = a;
    dataB = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
    busy_cyc = 0;
    done_cyc = -1;
    r = 32'hx;
    e = 2'bx;
    for (int i = 1; i <= 100; i++) begin
      if (busy) busy_cyc++;
      if (i == poke) begin
        dataA = 32'h3F80_0000;
        dataB = 32'h4040_0000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cyc = i;
        r = Resultado;
        e = esp;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] xr, input logic [1:0] xe, input int xlat,
                           input int poke);
    logic [31:0] r;
    logic [1:0]  e;
    int          bc, dc;
    do_op(a, b, poke, r, e, bc, dc);
    chk({tag, ".res"}, 64'(r), 64'(xr));
    chk({tag, ".esp"}, 64'(e), 64'(xe));
    chk({tag, ".lat"}, 64'(dc), 64'(xlat));
    chk({tag, ".busy"}, 64'(bc), 64'(xlat));
    @(negedge clk);
    chk({tag, ".idle"}, {62'h0, busy, done}, 64'h0);
    chk({tag, ".hold"}, {30'h0, esp, Resultado}, {30'h0, xe, xr});
  endtask

  logic [31:0] va [12] = '{32'h40C0_0000, 32'h3F80_0000, 32'hC0C0_0000, 32'h3F80_0000,
                           32'hC000_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h7F80_0000,
                           32'h7F80_0000, 32'h4000_0000, 32'h7F00_0000, 32'h0080_0000};
  logic [31:0] vb [12] = '{32'h4000_0000, 32'h4040_0000, 32'h4000_0000, 32'h0000_0000,
                           32'h0000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000,
                           32'h4000_0000, 32'h7F80_0000, 32'h0080_0000, 32'h7F00_0000};
  logic [31:0] vr [12] = '{32'h4040_0000, 32'h3EAA_AAAA, 32'hC040_0000, 32'h7F80_0000,
                           32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                           32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h0000_0000};
  logic [1:0]  ve [12] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01,
                           2'b01, 2'b01, 2'b11, 2'b00, 2'b11, 2'b00};
  int          vl [12] = '{28, 28, 28, 2, 2, 2, 2, 2, 2, 2, 28, 28};

  initial begin
    logic [34:0] m;
    logic [31:0] a, b;
    int          ndone, nrst_done, idle_wait;
    int          t [3];

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.outputs", {28'h0, busy, done, esp, Resultado}, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_check($sformatf("dir%0d", i), va[i], vb[i], vr[i], ve[i], vl[i], 0);
    end

    // Competing start during DIVIDE, then during DONE: both must be ignored.
    run_check("poke_divide", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 2'b00, 28, 10);
    run_check("poke_done", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 2'b00, 28, 28);

    for (int i = 0; i < 40; i++) begin
      a = rnd_operand();
      b = rnd_operand();
      m = model(a, b);
      run_check($sformatf("rnd%0d_%h_%h", i, a, b), a, b, m[31:0], m[33:32],
                m[34] ? 2 : 28, 0);
    end

    // Start held high: one op per 29 cycles, one done each.
    @(negedge clk);
    dataA = 32'hC0C0_0000;
    dataB = 32'h4000_0000;
    start = 1'b1;
    ndone = 0;
    t = '{-1, -1, -1};
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      if (done) begin
        if (ndone < 3) t[ndone] = i;
        ndone++;
        chk("held.res", 64'(Resultado), 64'hC040_0000);
      end
    end
    start = 1'b0;
    chk("held.ndone", 64'(ndone), 64'd3);
    chk("held.first", 64'(t[0]), 64'd28);
    chk("held.gap1", 64'(t[1] - t[0]), 64'd29);
    chk("held.gap2", 64'(t[2] - t[1]), 64'd29);
    idle_wait = 0;
    while (busy && idle_wait < 60) begin
      @(negedge clk);
      idle_wait++;
    end
    chk("held.drain", {63'h0, busy}, 64'h0);

    // Asynchronous reset in the middle of DIVIDE.
    @(negedge clk);
    dataA = 32'h40C0_0000;
    dataB = 32'h4000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset.busy", {63'h0, busy}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset.outputs", {28'h0, busy, done, esp, Resultado}, 64'h0);
    nrst_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) nrst_done++;
    end
    chk("mid_reset.quiet", 64'(nrst_done), 64'd0);
    rst_n = 1'b1;
    run_check("after_reset", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 2'b00, 28, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
